// File: rtl/idx_comp_encoder.sv
// Index-compression encoder: buffers one block while forwarding it to the MFA unit, then emits
// a header, and for each group of WIDTH_DATA elements a mask word plus the non-shared elements.
module idx_comp_encoder #(
  parameter int WIDTH_DATA  = 32,
  parameter int LENGTH      = 256,
  parameter int MIN_SHARE   = 2,
  parameter int MFA_TIMEOUT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Valid,
  input  logic                        I_Last,
  input  logic [WIDTH_DATA-1:0]       I_Data,
  output logic                        O_Rdy,
  output logic                        O_MFA_Valid,
  output logic [WIDTH_DATA-1:0]       O_MFA_Data,
  output logic                        O_Rd_MFA,
  output logic                        O_Rls,
  input  logic                        I_MFA_Valid,
  input  logic [WIDTH_DATA-1:0]       I_SharedData,
  input  logic [$clog2(LENGTH)+1:0]   I_CountVal,
  input  logic                        I_Rdy,
  output logic                        O_Valid,
  output logic [1:0]                  O_Tag,
  output logic [WIDTH_DATA-1:0]       O_Data,
  output logic                        O_Last,
  output logic                        O_Busy
);

  localparam int AW  = $clog2(LENGTH);
  localparam int CW  = AW + 1;
  localparam int CVW = AW + 2;
  localparam int JW  = $clog2(WIDTH_DATA);
  localparam int TW  = $clog2(MFA_TIMEOUT + 1);

  localparam logic [2:0] CAPTURE = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] HDR     = 3'd3;
  localparam logic [2:0] MASK    = 3'd4;
  localparam logic [2:0] DATA    = 3'd5;
  localparam logic [2:0] REL     = 3'd6;

  logic [2:0]            state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         base;      // index of element 0 of the current group
  logic [JW-1:0]         j;
  logic [TW-1:0]         timer;
  logic [WIDTH_DATA-1:0] shr;
  logic                  en;
  logic [WIDTH_DATA-1:0] mask_q;
  logic [WIDTH_DATA-1:0] blk_buf [LENGTH];

  logic                  accept;
  logic [WIDTH_DATA-1:0] in_range;
  logic [WIDTH_DATA-1:0] mask_now;
  logic [WIDTH_DATA-1:0] pend_vec;
  logic [CW-1:0]         cur_idx;
  logic                  cur_pend;
  logic                  later_pend;
  logic                  last_group;
  logic                  group_end;
  logic                  mask_full;

  assign accept = (state == CAPTURE) && I_Valid;

  // NOTE: the block buffer has no reset; every slot read during encode was written in capture.
  always_ff @(posedge clock) begin
    if (accept) blk_buf[count[AW-1:0]] <= I_Data;
  end

  // Parallel compare of the whole group against the shared value.
  always_comb begin
    in_range = '0;
    mask_now = '0;
    for (int i = 0; i < WIDTH_DATA; i++) begin
      in_range[i] = (base + CW'(i)) < count;
      mask_now[i] = en && in_range[i] && (blk_buf[AW'(base + CW'(i))] == shr);
    end
  end

  assign pend_vec   = in_range & ~mask_q;
  assign cur_idx    = base + CW'(j);
  assign cur_pend   = pend_vec[j];
  assign later_pend = |(pend_vec >> j >> 1);
  assign last_group = (base + CW'(WIDTH_DATA)) >= count;
  assign group_end  = (j == JW'(WIDTH_DATA - 1)) || (cur_idx == count - 1'b1);
  assign mask_full  = &(mask_now | ~in_range);

  always_comb begin
    O_Rdy       = (state == CAPTURE);
    O_MFA_Valid = accept;
    O_MFA_Data  = accept ? I_Data : '0;
    O_Rd_MFA    = (state == REQ);
    O_Rls       = (state == REL);
    O_Busy      = (state != CAPTURE) || (count != '0);
    O_Valid     = 1'b0;
    O_Tag       = 2'b00;
    O_Data      = '0;
    O_Last      = 1'b0;
    case (state)
      HDR: begin
        O_Valid = 1'b1;
        O_Data  = en ? shr : '0;
      end
      MASK: begin
        O_Valid = 1'b1;
        O_Tag   = 2'b01;
        O_Data  = mask_now;
        O_Last  = last_group && mask_full;
      end
      DATA: begin
        O_Valid = cur_pend;
        O_Tag   = 2'b10;
        O_Data  = cur_pend ? blk_buf[AW'(cur_idx)] : '0;
        O_Last  = cur_pend && last_group && !later_pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= CAPTURE;
      count  <= '0;
      base   <= '0;
      j      <= '0;
      timer  <= '0;
      shr    <= '0;
      en     <= 1'b0;
      mask_q <= '0;
    end else begin
      case (state)
        CAPTURE: if (I_Valid) begin
          count <= count + 1'b1;
          if (I_Last || count == CW'(LENGTH - 1)) state <= REQ;
        end
        REQ: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (I_MFA_Valid) begin
            shr   <= I_SharedData;
            en    <= I_CountVal >= CVW'(MIN_SHARE);
            state <= HDR;
          end else if (timer == TW'(MFA_TIMEOUT)) begin
            shr   <= '0;
            en    <= 1'b0;
            state <= HDR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HDR: if (I_Rdy) begin
          base  <= '0;
          state <= MASK;
        end
        MASK: if (I_Rdy) begin
          mask_q <= mask_now;
          j      <= '0;
          state  <= DATA;
        end
        DATA: if (!cur_pend || I_Rdy) begin
          if (group_end) begin
            base  <= base + CW'(WIDTH_DATA);
            state <= last_group ? REL : MASK;
          end else begin
            j <= j + 1'b1;
          end
        end
        REL: begin
          count <= '0;
          state <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_idx_comp_encoder.sv
// Directed bench for idx_comp_encoder: captures the output stream of each block and compares
// it with hand-built expected beats.
module tb_idx_comp_encoder;

  localparam int W   = 32;
  localparam int LEN = 256;

  typedef struct packed {
    logic [1:0]   tag;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Valid, I_Last, I_MFA_Valid, I_Rdy;
  logic [W-1:0]  I_Data, I_SharedData;
  logic [9:0]    I_CountVal;
  logic          O_Rdy, O_MFA_Valid, O_Rd_MFA, O_Rls, O_Valid, O_Last, O_Busy;
  logic [W-1:0]  O_MFA_Data, O_Data;
  logic [1:0]    O_Tag;

  beat_t         got[$];
  beat_t         exp_q[$];
  logic [W-1:0]  blk [LEN];
  int            checks = 0;
  int            errors = 0;
  int            first_valid;

  idx_comp_encoder dut (
    .clock(clock), .reset(reset),
    .I_Valid(I_Valid), .I_Last(I_Last), .I_Data(I_Data), .O_Rdy(O_Rdy),
    .O_MFA_Valid(O_MFA_Valid), .O_MFA_Data(O_MFA_Data),
    .O_Rd_MFA(O_Rd_MFA), .O_Rls(O_Rls),
    .I_MFA_Valid(I_MFA_Valid), .I_SharedData(I_SharedData), .I_CountVal(I_CountVal),
    .I_Rdy(I_Rdy), .O_Valid(O_Valid), .O_Tag(O_Tag), .O_Data(O_Data),
    .O_Last(O_Last), .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic beat_t mk(input logic [1:0] tag, input logic [W-1:0] data, input logic last);
    beat_t b;
    b.tag = tag; b.data = data; b.last = last;
    return b;
  endfunction

  function automatic string show(input beat_t q[$], input int i);
    if (i < q.size())
      return $sformatf("tag=%0d data=%h last=%0d", q[i].tag, q[i].data, q[i].last);
    return "none";
  endfunction

  // Index of the first differing beat, or -1 when both streams are identical.
  function automatic int first_diff();
    int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got[i] !== exp_q[i]) return i;
    if (got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic send_block(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      I_Valid = 1'b1; I_Data = blk[i]; I_Last = with_last && (i == n - 1);
      #1;
      checks++;
      if (O_Rdy !== 1'b1 || O_MFA_Valid !== 1'b1 || O_MFA_Data !== blk[i]) begin
        errors++;
        $display("FAIL fwd beat %0d: rdy=%b mfa_valid=%b mfa_data=%h, want 1 1 %h",
                 i, O_Rdy, O_MFA_Valid, O_MFA_Data, blk[i]);
      end
    end
    @(negedge clock);
    I_Valid = 1'b0; I_Last = 1'b0; I_Data = '0;
    #1;
  endtask

  task automatic mfa_respond(input bit answer, input logic [W-1:0] shr, input logic [9:0] cnt);
    int k = 0;
    while (O_Rd_MFA !== 1'b1 && k < 20) begin
      @(negedge clock); #1; k++;
    end
    checks++;
    if (O_Rd_MFA !== 1'b1) begin
      errors++;
      $display("FAIL rd_mfa: got no request in 20 cycles, want O_Rd_MFA=1");
    end else if (answer) begin
      @(negedge clock);
      I_MFA_Valid = 1'b1; I_SharedData = shr; I_CountVal = cnt;
      @(negedge clock);
      I_MFA_Valid = 1'b0; I_SharedData = '0; I_CountVal = '0;
    end
  endtask

  task automatic collect(input bit rnd, input int budget);
    beat_t held;
    bit    holding = 0;
    bit    done = 0;
    int    rd_extra = 0;
    got.delete();
    first_valid = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      I_Rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (holding) begin
        checks++;
        if (O_Valid !== 1'b1 || beat_t'({O_Tag, O_Data, O_Last}) !== held) begin
          errors++;
          $display("FAIL hold: got valid=%b tag=%0d data=%h last=%b, want tag=%0d data=%h last=%b",
                   O_Valid, O_Tag, O_Data, O_Last, held.tag, held.data, held.last);
        end
      end
      holding = 0;
      if (O_Rd_MFA === 1'b1) rd_extra++;
      if (O_Rls === 1'b1) done = 1;
      else if (O_Valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (I_Rdy) got.push_back(beat_t'({O_Tag, O_Data, O_Last}));
        else begin
          held = beat_t'({O_Tag, O_Data, O_Last});
          holding = 1;
        end
      end
    end
    I_Rdy = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rls: got no O_Rls within %0d cycles, want one pulse", budget);
    end
    checks++;
    if (rd_extra != 0) begin
      errors++;
      $display("FAIL rd_mfa pulse: got %0d extra request cycles, want 0", rd_extra);
    end
    if (done) begin
      @(negedge clock); #1;
      checks++;
      if (O_Rls !== 1'b0 || O_Rdy !== 1'b1 || O_Busy !== 1'b0) begin
        errors++;
        $display("FAIL after rls: got rls=%b rdy=%b busy=%b, want 0 1 0", O_Rls, O_Rdy, O_Busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    I_Valid = 0; I_Last = 0; I_Data = '0; I_MFA_Valid = 0; I_SharedData = '0;
    I_CountVal = '0; I_Rdy = 0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (O_Rdy !== 1'b1 || O_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset rdy/busy: got %b %b, want 1 0", O_Rdy, O_Busy);
    end
    checks++;
    if (O_Valid !== 1'b0 || O_Tag !== 2'b00 || O_Data !== '0 || O_Last !== 1'b0) begin
      errors++;
      $display("FAIL reset out: got valid=%b tag=%0d data=%h last=%b, want all 0",
               O_Valid, O_Tag, O_Data, O_Last);
    end
    checks++;
    if (O_Rd_MFA !== 1'b0 || O_Rls !== 1'b0 || O_MFA_Valid !== 1'b0 || O_MFA_Data !== '0) begin
      errors++;
      $display("FAIL reset mfa: got rd=%b rls=%b mv=%b md=%h, want all 0",
               O_Rd_MFA, O_Rls, O_MFA_Valid, O_MFA_Data);
    end
    reset = 1'b0;
  endtask

  task automatic test_all_shared();
    int d;
    for (int i = 0; i < 32; i++) blk[i] = 32'd5;
    send_block(32, 1);
    mfa_respond(1, 32'd5, 10'd32);
    collect(0, 200);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 32'd5, 1'b0));
    exp_q.push_back(mk(2'd1, 32'hFFFF_FFFF, 1'b1));
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL all_shared beat %0d: got %s (%0d beats), want %s (%0d beats)",
               d, show(got, d), got.size(), show(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_alternating();
    int d;
    for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? 32'd0 : 32'd7;
    send_block(64, 1);
    mfa_respond(1, 32'd0, 10'd32);
    collect(0, 400);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 32'd0, 1'b0));
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back(mk(2'd1, 32'h5555_5555, 1'b0));
      for (int k = 0; k < 16; k++) exp_q.push_back(mk(2'd2, 32'd7, g == 1 && k == 15));
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL alternating beat %0d: got %s (%0d beats), want %s (%0d beats)",
               d, show(got, d), got.size(), show(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_below_share();
    int d;
    for (int i = 0; i < 20; i++) blk[i] = 32'(i * 3 + 1);
    send_block(20, 1);
    mfa_respond(1, 32'd1, 10'd1);
    collect(0, 300);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 32'd0, 1'b0));
    exp_q.push_back(mk(2'd1, 32'd0, 1'b0));
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(2'd2, 32'(i * 3 + 1), i == 19));
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL below_share beat %0d: got %s (%0d beats), want %s (%0d beats)",
               d, show(got, d), got.size(), show(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int d;
    for (int i = 0; i < 40; i++) blk[i] = 32'h100 + 32'(i);
    blk[3] = 32'd0;
    send_block(40, 1);
    mfa_respond(0, 32'd0, 10'd0);
    collect(0, 400);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 32'd0, 1'b0));
    exp_q.push_back(mk(2'd1, 32'd0, 1'b0));
    for (int i = 0; i < 32; i++) exp_q.push_back(mk(2'd2, blk[i], 1'b0));
    exp_q.push_back(mk(2'd1, 32'd0, 1'b0));
    for (int i = 32; i < 40; i++) exp_q.push_back(mk(2'd2, blk[i], i == 39));
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL timeout beat %0d: got %s (%0d beats), want %s (%0d beats)",
               d, show(got, d), got.size(), show(exp_q, d), exp_q.size());
    end
    checks++;
    if (first_valid < 8 || first_valid > 12) begin
      errors++;
      $display("FAIL timeout delay: got header %0d cycles after request, want 8..12", first_valid + 1);
    end
  endtask

  task automatic test_full_random();
    int d;
    for (int i = 0; i < LEN; i++) blk[i] = (i % 4 == 1) ? 32'hA5 : {16'hC0DE, 16'(i)};
    send_block(LEN, 0);
    I_Valid = 1'b1; I_Data = 32'hDEAD;
    #1;
    checks++;
    if (O_Rdy !== 1'b0 || O_MFA_Valid !== 1'b0) begin
      errors++;
      $display("FAIL full block: got rdy=%b mfa_valid=%b after beat 256, want 0 0", O_Rdy, O_MFA_Valid);
    end
    I_Valid = 1'b0; I_Data = '0;
    mfa_respond(1, 32'hA5, 10'd64);
    collect(1, 3000);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 32'hA5, 1'b0));
    for (int g = 0; g < LEN / W; g++) begin
      exp_q.push_back(mk(2'd1, 32'h2222_2222, 1'b0));
      for (int i = g * W; i < (g + 1) * W; i++)
        if (i % 4 != 1) exp_q.push_back(mk(2'd2, blk[i], i == LEN - 1));
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL full_random beat %0d: got %s (%0d beats), want %s (%0d beats)",
               d, show(got, d), got.size(), show(exp_q, d), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_data();
    int n_data = 0;
    for (int i = 0; i < 20; i++) blk[i] = 32'(i * 3 + 1);
    send_block(20, 1);
    mfa_respond(1, 32'd1, 10'd1);
    for (int c = 0; c < 50 && n_data < 2; c++) begin
      @(negedge clock);
      I_Rdy = 1'b1;
      #1;
      if (O_Valid === 1'b1 && O_Tag === 2'b10) n_data++;
    end
    checks++;
    if (n_data != 2) begin
      errors++;
      $display("FAIL mid reset setup: got %0d data beats, want 2", n_data);
    end
    @(negedge clock);
    I_Rdy = 1'b0; reset = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (O_Valid !== 1'b0 || O_Rdy !== 1'b1 || O_Rls !== 1'b0 || O_Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got valid=%b rdy=%b rls=%b busy=%b, want 0 1 0 0",
               O_Valid, O_Rdy, O_Rls, O_Busy);
    end
    reset = 1'b0;
    test_below_share();
  endtask

  initial begin
    test_reset();
    test_all_shared();
    test_alternating();
    test_below_share();
    test_timeout();
    test_full_random();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
